// File: rtl/sq_pkg.sv
// Shared types and helpers for the post-writeback store queue.
// Size encodings, the queue entry record, the default depth, and the
// dword-index helper used by the load/store overlap comparators.
package sq_pkg;

  localparam int unsigned SQ_DEPTH_DEFAULT = 4;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } sq_entry_t;

  // Access length minus one; the reserved encoding behaves as a dword.
  function automatic logic [1:0] sz_len_m1(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_WORD: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Dword index of the last byte touched. The carry out of the low two
  // bits is all that matters; the 30-bit add wraps exactly like a 32-bit
  // byte address would.
  function automatic logic [29:0] last_dword(input logic [31:0] addr,
                                             input logic [1:0]  size);
    logic carry;
    carry = ({1'b0, addr[1:0]} + {1'b0, sz_len_m1(size)}) > 3'd3;
    return addr[31:2] + {29'd0, carry};
  endfunction

endpackage

// File: rtl/sq_overlap_cmp.sv
// One store-entry vs. load overlap comparator at dword granularity.
// Each access spans at most two dwords (first and last); a conflict is
// any equality between a store dword and a load dword.
module sq_overlap_cmp
  import sq_pkg::*;
(
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        overlap
);

  logic [29:0] st_first, st_last, ld_first, ld_last;

  assign st_first = st_addr[31:2];
  assign ld_first = ld_addr[31:2];
  assign st_last  = last_dword(st_addr, st_size);
  assign ld_last  = last_dword(ld_addr, ld_size);

  assign overlap = (st_first == ld_first) | (st_first == ld_last) |
                   (st_last  == ld_first) | (st_last  == ld_last);

endmodule

// File: rtl/store_queue_wb.sv
// Post-writeback store queue: circular FIFO of retired stores drained in
// order to the dcache over req/ack, with full backpressure to WB and a
// load-conflict flag for the memory stage.
// Optional feature macro: SQ_OVERLAP_CHECK_EN. When defined, ld_conflict
// compares the load against every occupied entry; otherwise any pending
// store stalls all loads.
module store_queue_wb
  import sq_pkg::*;
#(
  parameter int unsigned DEPTH = SQ_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        wb_st_valid,
  input  logic [31:0] wb_st_addr,
  input  logic [31:0] wb_st_data,
  input  logic [1:0]  wb_st_size,
  output logic        sq_full,
  output logic        sq_empty,
  output logic        dc_wr_req,
  output logic [31:0] dc_wr_addr,
  output logic [31:0] dc_wr_data,
  output logic [1:0]  dc_wr_size,
  input  logic        dc_wr_ack,
  input  logic [31:0] ld_chk_addr,
  input  logic [1:0]  ld_chk_size,
  output logic        ld_conflict
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  sq_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [PTR_W:0]   cnt;
  logic             push, pop;

  // Full is taken from the registered count, so a same-cycle pop never
  // frees a slot for a push.
  assign sq_full   = (cnt == CNT_FULL);
  assign sq_empty  = (cnt == '0);
  assign dc_wr_req = ~sq_empty;
  assign push      = wb_st_valid & ~sq_full;
  assign pop       = dc_wr_req & dc_wr_ack;

  assign dc_wr_addr = entries[rp].addr;
  assign dc_wr_data = entries[rp].data;
  assign dc_wr_size = entries[rp].size;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; cleared on reset so the idle payload reads as zero.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
    end else if (push) begin
      entries[wp] <= '{addr: wb_st_addr, data: wb_st_data, size: wb_st_size};
    end
  end

`ifdef SQ_OVERLAP_CHECK_EN
  logic [DEPTH-1:0] occ, hit;
  logic [PTR_W-1:0] off;

  // An entry is live when its distance from rp is below the occupancy.
  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off    = PTR_W'(i) - rp;
      occ[i] = ({1'b0, off} < cnt);
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_cmp
    sq_overlap_cmp u_cmp (
      .st_addr (entries[g].addr),
      .st_size (entries[g].size),
      .ld_addr (ld_chk_addr),
      .ld_size (ld_chk_size),
      .overlap (hit[g])
    );
  end

  assign ld_conflict = |(occ & hit);
`else
  logic unused_ld_chk;

  assign unused_ld_chk = ^{ld_chk_addr, ld_chk_size};
  assign ld_conflict   = ~sq_empty;
`endif

endmodule

// File: tb/tb_store_queue_wb.sv
// Self-checking bench for store_queue_wb: a directed table, hand-written
// corner sequences and a randomized run against a queue-based model whose
// overlap rule enumerates the individual bytes of each access.
module tb_store_queue_wb;

  localparam int DEPTH = 4;
`ifdef SQ_OVERLAP_CHECK_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        wb_st_valid = 1'b0;
  logic [31:0] wb_st_addr = '0;
  logic [31:0] wb_st_data = '0;
  logic [1:0]  wb_st_size = '0;
  logic        sq_full, sq_empty, dc_wr_req;
  logic [31:0] dc_wr_addr, dc_wr_data;
  logic [1:0]  dc_wr_size;
  logic        dc_wr_ack = 1'b0;
  logic [31:0] ld_chk_addr = '0;
  logic [1:0]  ld_chk_size = '0;
  logic        ld_conflict;

  store_queue_wb #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .wb_st_valid (wb_st_valid),
    .wb_st_addr  (wb_st_addr),
    .wb_st_data  (wb_st_data),
    .wb_st_size  (wb_st_size),
    .sq_full     (sq_full),
    .sq_empty    (sq_empty),
    .dc_wr_req   (dc_wr_req),
    .dc_wr_addr  (dc_wr_addr),
    .dc_wr_data  (dc_wr_data),
    .dc_wr_size  (dc_wr_size),
    .dc_wr_ack   (dc_wr_ack),
    .ld_chk_addr (ld_chk_addr),
    .ld_chk_size (ld_chk_size),
    .ld_conflict (ld_conflict)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        ack;
    logic [31:0] la;
    logic [1:0]  ls;
    logic        e_req;
    logic        e_full;
    logic        e_empty;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_conf;
  } vec_t;

  st_t mq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Two accesses clash when any byte of one lies in the same aligned
  // 4-byte block as any byte of the other.
  function automatic bit overlaps(input logic [31:0] a1, input logic [1:0] s1,
                                  input logic [31:0] a2, input logic [1:0] s2);
    logic [31:0] b1, b2;
    for (int i = 0; i < len_of(s1); i++) begin
      for (int j = 0; j < len_of(s2); j++) begin
        b1 = a1 + 32'(i);
        b2 = a2 + 32'(j);
        if ((b1 >> 2) == (b2 >> 2)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit model_conflict(input logic [31:0] la, input logic [1:0] ls);
    if (!OVL) return mq.size() != 0;
    foreach (mq[k]) if (overlaps(mq[k].addr, mq[k].size, la, ls)) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of stimulus, compare against the model, then advance
  // the model and the clock.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic ack,
                       input logic [31:0] la, input logic [1:0] ls);
    bit pop, push;
    wb_st_valid = v; wb_st_addr = a; wb_st_data = d; wb_st_size = s;
    dc_wr_ack = ack; ld_chk_addr = la; ld_chk_size = ls;
    #1;
    chk("m_req",   32'(dc_wr_req),   32'(mq.size() != 0));
    chk("m_empty", 32'(sq_empty),    32'(mq.size() == 0));
    chk("m_full",  32'(sq_full),     32'(mq.size() == DEPTH));
    chk("m_conf",  32'(ld_conflict), 32'(model_conflict(la, ls)));
    if (mq.size() != 0) begin
      chk("m_addr", dc_wr_addr, mq[0].addr);
      chk("m_data", dc_wr_data, mq[0].data);
      chk("m_size", 32'(dc_wr_size), 32'(mq[0].size));
    end
    pop  = (mq.size() != 0) && ack;
    push = v && (mq.size() != DEPTH);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back('{addr: a, data: d, size: s});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, '0, '0, 2'b00, ack, 32'h0000_9000, 2'b00);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    cycle(1'b1, a, d, s, 1'b0, 32'h0000_9000, 2'b00);
  endtask

  // Assert reset away from a clock edge and check outputs drop at once.
  task automatic do_reset(input string tag);
    @(posedge CLK);
    #2;
    wb_st_valid = 1'b0; dc_wr_ack = 1'b0;
    CLR = 1'b0;
    #1;
    chk({tag, "_req"},   32'(dc_wr_req),   32'd0);
    chk({tag, "_empty"}, 32'(sq_empty),    32'd1);
    chk({tag, "_full"},  32'(sq_full),     32'd0);
    chk({tag, "_conf"},  32'(ld_conflict), 32'd0);
    chk({tag, "_addr"},  dc_wr_addr,       32'd0);
    chk({tag, "_data"},  dc_wr_data,       32'd0);
    chk({tag, "_size"},  32'(dc_wr_size),  32'd0);
    mq.delete();
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b1;
  endtask

  task automatic probe(input string name, input logic [31:0] la, input logic [1:0] ls,
                       input logic exp);
    wb_st_valid = 1'b0; dc_wr_ack = 1'b0;
    ld_chk_addr = la; ld_chk_size = ls;
    #1;
    chk(name, 32'(ld_conflict), 32'(exp));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00,
                1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h1000, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 2'b00,
                1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h1000, 2'b00,
                1'b1, 1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b1};
    for (int i = 3; i < 7; i++)
      vecs[i] = '{1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h3000, 2'b10,
                  1'b1, 1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, !OVL};
    vecs[7] = '{1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h3000, 2'b10,
                1'b1, 1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, !OVL};
    vecs[8] = '{1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h3000, 2'b10,
                1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};

    do_reset("rst0");

    // Directed table: single dword push, hold, drain.
    for (int i = 0; i < 9; i++) begin
      wb_st_valid = vecs[i].v; wb_st_addr = vecs[i].a; wb_st_data = vecs[i].d;
      wb_st_size = vecs[i].s; dc_wr_ack = vecs[i].ack;
      ld_chk_addr = vecs[i].la; ld_chk_size = vecs[i].ls;
      #1;
      chk($sformatf("t%0d_req", i),   32'(dc_wr_req),   32'(vecs[i].e_req));
      chk($sformatf("t%0d_full", i),  32'(sq_full),     32'(vecs[i].e_full));
      chk($sformatf("t%0d_empty", i), 32'(sq_empty),    32'(vecs[i].e_empty));
      chk($sformatf("t%0d_addr", i),  dc_wr_addr,       vecs[i].e_addr);
      chk($sformatf("t%0d_data", i),  dc_wr_data,       vecs[i].e_data);
      chk($sformatf("t%0d_conf", i),  32'(ld_conflict), 32'(vecs[i].e_conf));
      cycle(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].ack,
            vecs[i].la, vecs[i].ls);
    end

    // Fill to full, drop a fifth push, drain in order, then wrap.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) push_st(32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 2'b10);
    chk("fill_full", 32'(sq_full), 32'd1);
    push_st(32'h500, 32'hBAD, 2'b10);
    chk("drop_full", 32'(sq_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), dc_wr_data, 32'hA000 + 32'(i));
      idle(1'b1);
    end
    chk("drained_empty", 32'(sq_empty), 32'd1);
    push_st(32'h600, 32'hC0DE, 2'b01);
    chk("wrap_addr", dc_wr_addr, 32'h600);
    chk("wrap_data", dc_wr_data, 32'hC0DE);
    idle(1'b1);

    // Push and ack together: refused when full, neutral otherwise.
    do_reset("rst2");
    for (int i = 0; i < 4; i++) push_st(32'h200 + 32'(i), 32'hB000 + 32'(i), 2'b00);
    cycle(1'b1, 32'h777, 32'h777, 2'b00, 1'b1, 32'h9000, 2'b00);
    chk("pa_full_cnt3", 32'(sq_full), 32'd0);
    push_st(32'h800, 32'h800, 2'b00);
    chk("pa_refill", 32'(sq_full), 32'd1);
    do_reset("rst3");
    push_st(32'h300, 32'h1, 2'b00);
    push_st(32'h304, 32'h2, 2'b00);
    cycle(1'b1, 32'h308, 32'h3, 2'b00, 1'b1, 32'h9000, 2'b00);
    chk("pa_head", dc_wr_data, 32'h2);
    idle(1'b1);
    chk("pa_cnt1", 32'(sq_empty), 32'd0);
    idle(1'b1);
    chk("pa_cnt0", 32'(sq_empty), 32'd1);

    // Dword-granular overlap and address wrap.
    do_reset("rst4");
    push_st(32'h2003, 32'h55, 2'b01);
    probe("ovl_2004", 32'h2004, 2'b10, 1'b1);
    probe("ovl_2008", 32'h2008, 2'b00, !OVL);
    probe("ovl_1fff", 32'h1FFF, 2'b00, !OVL);
    idle(1'b1);
    probe("ovl_empty", 32'h2004, 2'b10, 1'b0);
    push_st(32'hFFFF_FFFE, 32'h66, 2'b10);
    probe("ovl_wrap", 32'h0000_0001, 2'b00, 1'b1);
    probe("ovl_wrap_miss", 32'h0000_0004, 2'b00, !OVL);
    idle(1'b1);

    // Reset while draining discards everything.
    for (int i = 0; i < 3; i++) push_st(32'h400 + 32'(i * 4), 32'hD0 + 32'(i), 2'b10);
    chk("pre_rst_req", 32'(dc_wr_req), 32'd1);
    do_reset("rst5");
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a, la;
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 15))
                                       : 32'h0000_4000 + 32'($urandom_range(0, 23));
      la = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 15))
                                       : 32'h0000_4000 + 32'($urandom_range(0, 23));
      cycle($urandom_range(0, 9) < 6, a, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, la, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
